// File: rtl/vga_mem_arbiter.sv
// Single-port memory arbiter between the VGA line fetcher and the CPU.
// VGA has fixed priority; a starvation guard forces one CPU access in.
module vga_mem_arbiter #(
    parameter int ADDR_WIDTH   = 20,
    parameter int DATA_WIDTH   = 48,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] vga_addr,
    input  logic                  vga_sel,
    output logic                  vga_valid,
    output logic [DATA_WIDTH-1:0] vga_data,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_sel,
    input  logic                  cpu_we,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ready,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  busy
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        VGA_BUSY,
        CPU_BUSY
    } state_t;

    state_t                state;
    state_t                state_d;
    logic [SW-1:0]         streak;
    logic [SW-1:0]         streak_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  we_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic                  starve;

    assign starve = cpu_sel && (streak == LIMIT);

    // State, streak and memory-side request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            streak    <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            state     <= state_d;
            streak    <= streak_d;
            mem_addr  <= addr_d;
            mem_we    <= we_d;
            mem_wdata <= wdata_d;
        end
    end

    // Arbitration in IDLE, wait for the ack while busy
    always_comb begin
        state_d  = state;
        streak_d = streak;
        addr_d   = mem_addr;
        we_d     = mem_we;
        wdata_d  = mem_wdata;
        unique case (state)
            IDLE: begin
                if (starve || (cpu_sel && !vga_sel)) begin
                    state_d  = CPU_BUSY;
                    addr_d   = cpu_addr;
                    we_d     = cpu_we;
                    wdata_d  = cpu_wdata;
                    streak_d = '0;
                end else if (vga_sel) begin
                    state_d = VGA_BUSY;
                    addr_d  = vga_addr;
                    we_d    = 1'b0;
                    wdata_d = '0;
                    if (!cpu_sel)
                        streak_d = '0;
                    else if (streak != LIMIT)
                        streak_d = streak + 1'b1;
                end else begin
                    streak_d = '0;
                end
            end
            VGA_BUSY, CPU_BUSY: begin
                if (mem_ack)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_req   = (state != IDLE);
    assign busy      = (state != IDLE);
    assign vga_valid = !rst && mem_ack && (state == VGA_BUSY) && vga_sel;
    assign cpu_ready = !rst && mem_ack && (state == CPU_BUSY);
    assign vga_data  = mem_rdata;
    assign cpu_rdata = mem_rdata;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed bench for vga_mem_arbiter: reset, VGA read, CPU write,
// priority, starvation guard, abort, reset mid-transaction, spurious ack.
module tb_vga_mem_arbiter;

    localparam int AW = 20;
    localparam int DW = 48;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] vga_addr;
    logic          vga_sel;
    logic          vga_valid;
    logic [DW-1:0] vga_data;
    logic [AW-1:0] cpu_addr;
    logic          cpu_sel;
    logic          cpu_we;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ready;
    logic [DW-1:0] cpu_rdata;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    vga_mem_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .vga_addr (vga_addr),
        .vga_sel  (vga_sel),
        .vga_valid(vga_valid),
        .vga_data (vga_data),
        .cpu_addr (cpu_addr),
        .cpu_sel  (cpu_sel),
        .cpu_we   (cpu_we),
        .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready),
        .cpu_rdata(cpu_rdata),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one edge; inputs change 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
    endtask

    // present an ack for the current cycle and let outputs settle
    task automatic ack(input logic [DW-1:0] d);
        mem_ack   = 1'b1;
        mem_rdata = d;
        #1;
    endtask

    initial begin
        logic [AW-1:0] exp_addr;
        logic          exp_cpu;

        rst       = 1'b1;
        vga_addr  = '0;
        vga_sel   = 1'b0;
        cpu_addr  = '0;
        cpu_sel   = 1'b0;
        cpu_we    = 1'b0;
        cpu_wdata = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;

        // reset state
        tick();
        tick();
        ack(48'h111111111111);
        check("rst_req", 64'(mem_req), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_we", 64'(mem_we), 64'd0);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        check("rst_vvalid", 64'(vga_valid), 64'd0);
        check("rst_cready", 64'(cpu_ready), 64'd0);
        check("rst_streak", 64'(dut.streak), 64'd0);

        // single VGA read, ack 3 cycles after mem_req
        tick();
        rst      = 1'b0;
        vga_sel  = 1'b1;
        vga_addr = 20'h00100;
        tick();
        check("v1_req", 64'(mem_req), 64'd1);
        check("v1_busy", 64'(busy), 64'd1);
        check("v1_addr", 64'(mem_addr), 64'h00100);
        check("v1_we", 64'(mem_we), 64'd0);
        tick();
        tick();
        check("v1_wait_valid", 64'(vga_valid), 64'd0);
        check("v1_hold_req", 64'(mem_req), 64'd1);
        tick();
        ack(48'hABCDEF012345);
        check("v1_valid", 64'(vga_valid), 64'd1);
        check("v1_data", 64'(vga_data), 64'hABCDEF012345);
        check("v1_cready", 64'(cpu_ready), 64'd0);
        tick();
        vga_addr = 20'h00101;
        #1;
        check("v1_gap_req", 64'(mem_req), 64'd0);
        check("v1_gap_valid", 64'(vga_valid), 64'd0);
        tick();
        check("v2_req", 64'(mem_req), 64'd1);
        check("v2_addr", 64'(mem_addr), 64'h00101);
        ack(48'h000000000777);
        check("v2_valid", 64'(vga_valid), 64'd1);
        tick();
        vga_sel = 1'b0;
        tick();
        check("v2_idle", 64'(mem_req), 64'd0);

        // CPU write, ack after 1 cycle
        cpu_sel   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 20'h00042;
        cpu_wdata = 48'h55;
        tick();
        check("cw_req", 64'(mem_req), 64'd1);
        check("cw_we", 64'(mem_we), 64'd1);
        check("cw_addr", 64'(mem_addr), 64'h00042);
        check("cw_wdata", 64'(mem_wdata), 64'h55);
        tick();
        check("cw_wait_ready", 64'(cpu_ready), 64'd0);
        ack(48'h0);
        check("cw_ready", 64'(cpu_ready), 64'd1);
        check("cw_vvalid", 64'(vga_valid), 64'd0);
        tick();
        cpu_sel = 1'b0;
        cpu_we  = 1'b0;
        #1;
        check("cw_ready_pulse", 64'(cpu_ready), 64'd0);
        check("cw_gap_req", 64'(mem_req), 64'd0);
        tick();

        // priority and starvation: both held high, ack latency 1
        vga_sel  = 1'b1;
        vga_addr = 20'h00200;
        cpu_sel  = 1'b1;
        cpu_addr = 20'h00077;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp_cpu  = (i == 8);
            exp_addr = exp_cpu ? 20'h00077 : vga_addr;
            check($sformatf("st%0d_addr", i), 64'(mem_addr),
                  64'(exp_addr));
            check($sformatf("st%0d_streak", i), 64'(dut.streak),
                  (i < 8) ? 64'(i + 1) : (i == 8 ? 64'd0 : 64'd1));
            ack(48'h000000C0FFEE);
            check($sformatf("st%0d_vvalid", i), 64'(vga_valid),
                  64'(!exp_cpu));
            check($sformatf("st%0d_cready", i), 64'(cpu_ready),
                  64'(exp_cpu));
            tick();
            if (!exp_cpu)
                vga_addr = vga_addr + 1'b1;
            if (i == 9) begin
                vga_sel = 1'b0;
                cpu_sel = 1'b0;
            end
            #1;
            check($sformatf("st%0d_gap", i), 64'(mem_req), 64'd0);
        end
        tick();

        // VGA drops sel before ack: transaction completes silently
        vga_sel  = 1'b1;
        vga_addr = 20'h00300;
        tick();
        check("ab_req", 64'(mem_req), 64'd1);
        vga_sel = 1'b0;
        tick();
        ack(48'h123);
        check("ab_vvalid", 64'(vga_valid), 64'd0);
        check("ab_cready", 64'(cpu_ready), 64'd0);
        tick();
        check("ab_done", 64'(mem_req), 64'd0);
        tick();

        // reset mid-transaction, then a late ack
        vga_sel  = 1'b1;
        vga_addr = 20'h00400;
        tick();
        check("rm_req", 64'(mem_req), 64'd1);
        tick();
        rst = 1'b1;
        ack(48'h456);
        check("rm_rst_vvalid", 64'(vga_valid), 64'd0);
        tick();
        check("rm_req_drop", 64'(mem_req), 64'd0);
        check("rm_busy_drop", 64'(busy), 64'd0);
        rst     = 1'b0;
        vga_sel = 1'b0;
        ack(48'h789);
        check("rm_late_vvalid", 64'(vga_valid), 64'd0);
        check("rm_late_cready", 64'(cpu_ready), 64'd0);
        tick();
        check("rm_idle_req", 64'(mem_req), 64'd0);
        check("rm_idle_addr", 64'(mem_addr), 64'd0);

        // spurious ack while idle with no requests
        ack(48'hFFFFFFFFFFFF);
        check("sp_vvalid", 64'(vga_valid), 64'd0);
        check("sp_cready", 64'(cpu_ready), 64'd0);
        tick();
        check("sp_req", 64'(mem_req), 64'd0);
        check("sp_busy", 64'(busy), 64'd0);
        check("sp_addr", 64'(mem_addr), 64'd0);
        check("sp_we", 64'(mem_we), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
